cell_assembler: RTL and testbench
=================================

Name: cell_assembler

Overview:
- Collects a 10x10 pixel neighbourhood, one row per beat, from the frame-fetch row stream.
- Packs the rows into one 768-bit cell word: 8x8 inner pixels plus four 8-pixel border strips. Corner pixels are dropped.
- Generates the top/bottom/left/right mask enables from the cell's position in the frame.
- Feeds the cell masking stage directly: cell_o and the *_msk_en_o outputs connect to its cell and mask-enable inputs.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel
- CELL_ROW_PNUM, 8, inner pixels per cell row
- CELL_COL_PNUM, 8, inner pixel rows per cell
- CELL_WIDTH, 768, packed cell width; must equal (ROW*COL + 2*ROW + 2*COL)*PIXEL_WIDTH
- FRAME_CELL_COLS, 40, cells per frame row
- FRAME_CELL_ROWS, 30, cell rows per frame

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- row_i  in  (CELL_ROW_PNUM+2)*PIXEL_WIDTH = 80  one neighbourhood row; pixel 0 (leftmost) in [79:72], pixel 9 in [7:0]
- row_valid_i  in  1  row_i valid
- row_ready_o  out  1  assembler accepts a row
- cell_o  out  CELL_WIDTH  packed cell
- cell_valid_o  out  1  cell_o and mask enables valid
- cell_ready_i  in  1  downstream accepts the cell
- t_msk_en_o  out  1  cell is in the top cell row of the frame
- b_msk_en_o  out  1  cell is in the bottom cell row of the frame
- l_msk_en_o  out  1  cell is in the left cell column of the frame
- r_msk_en_o  out  1  cell is in the right cell column of the frame
- cell_col_o  out  $clog2(FRAME_CELL_COLS)  column index of the presented cell
- cell_row_o  out  $clog2(FRAME_CELL_ROWS)  row index of the presented cell
- frame_done_o  out  1  one-cycle pulse when the last cell of a frame is accepted

Behaviour:
- Handshakes
  - Row is taken on row_valid_i & row_ready_o.
  - Cell is taken on cell_valid_o & cell_ready_i.
  - Valid/ready: once asserted, cell_valid_o and every cell output hold stable until accepted.
- Reset (synchronous, clk rising edge)
  - State goes to FILL, beat count to 0, cell_col/cell_row to 0.
  - cell_valid_o=0, frame_done_o=0, cell_o=0, all mask enables=0.
  - row_ready_o=1 in the first cycle after reset.
  - A reset mid-fill or mid-hold discards partial or unsent data; the next row after reset is beat 0.
- FSM state FILL
  - row_ready_o=1.
  - Beat counter runs 0..9 and increments on each row handshake.
  - Beat 0: pixels 1..8 -> top strip; pixels 0 and 9 discarded.
  - Beat k=1..8: pixel 0 -> left strip element k-1; pixels 1..8 -> inner row k-1; pixel 9 -> right strip element k-1.
  - Beat 9: pixels 1..8 -> bottom strip; corners discarded.
  - Handshake on beat 9 moves to HOLD.
  - Gaps in row_valid_i stall the count without losing state.
- FSM state HOLD
  - row_ready_o=0.
  - cell_valid_o=1 from the cycle after the beat-9 handshake (latency 1).
  - cell_ready_i=0 holds everything.
  - On cell handshake: go to FILL, clear the beat counter, advance the position. row_ready_o=1 in the next cycle.
  - Throughput: one cell per 11 cycles minimum; no overlap of fill and hold.
- Packing (MSB first)
  - cell_o = {inner, top, left, right, bottom}.
  - inner = [767:256]; inner row 0 is [767:704]; within a row, pixel 1 (leftmost inner) sits at the MSB.
  - top = [255:192], left = [191:128], right = [127:64], bottom = [63:0]; strip element 0 sits at the MSB.
- Mask enables (registered; updated when entering HOLD)
  - t = (row==0)
  - b = (row==FRAME_CELL_ROWS-1)
  - l = (col==0)
  - r = (col==FRAME_CELL_COLS-1)
  - All four may be 1 together, e.g. a 1x1 frame.
- Position update on cell handshake
  - col increments; at FRAME_CELL_COLS-1 it wraps to 0 and row increments.
  - At the last column of the last row, both wrap to 0 and frame_done_o pulses in the following cycle for exactly one cycle.
- cell_row_o/cell_col_o always show the position of the cell being filled or held.
- Outputs are undefined-free: no X after reset.

Test Plan:
- Single cell, default params. Beat b pixel p = {b[3:0],p[3:0]}, no stalls.
  - cell_valid_o rises 1 cycle after beat 9.
  - inner row0 = 0x11..0x18; top = 0x01..0x08; left = 0x10..0x80; right = 0x19..0x89; bottom = 0x91..0x98.
  - t=1, l=1, b=0, r=0.
- FRAME_CELL_COLS=2, FRAME_CELL_ROWS=2, four cells. Mask sets:
  - cell 0 = {t,l}, cell 1 = {t,r}, cell 2 = {b,l}, cell 3 = {b,r}.
  - frame_done_o pulses once, after cell 3 is accepted.
  - Fifth cell is back to col=0, row=0.
- Backpressure: hold cell_ready_i=0 for 20 cycles with row_valid_i=1.
  - row_ready_o stays 0; cell_o and mask enables stay stable.
  - Accept: row_ready_o=1 the next cycle.
- Random row_valid_i gaps (50% duty) over 3 cells.
  - Packed cells match the reference model bit-exact; no rows are dropped or duplicated.
- Assert rst after 5 accepted beats.
  - Next cycle: cell_valid_o=0, col/row=0.
  - The following 10 beats form a clean cell with no remnants of the first 5.
- 1x1 frame (both frame params = 1).
  - Every cell has t=b=l=r=1.
  - frame_done_o pulses after every accepted cell.

Source files
------------

// File: rtl/cell_assembler.sv
// -----------------------------------------------------------------------------
// cell_assembler
//
// Purpose:
//   Collects a (CELL_ROW_PNUM+2) x (CELL_COL_PNUM+2) pixel neighbourhood from
//   the frame-fetch row stream, one row per beat. It packs the rows into a
//   single cell word made of the inner pixel block plus four border strips.
//   The four corner pixels are dropped. The assembler also tracks where the
//   cell sits in the frame and raises top/bottom/left/right mask enables for
//   the cell masking stage that follows.
//
// Packing (MSB first):
//   cell_o = {inner, top, left, right, bottom}
//   In inner, row 0 is at the top. Within a row, the leftmost inner pixel is
//   at the MSB. In every strip, element 0 is at the MSB.
//
// Ports:
//   clk           clock; all logic runs on the rising edge
//   rst           synchronous active-high reset
//   row_i         one neighbourhood row; pixel 0 (leftmost) in the top bits
//   row_valid_i   row_i valid
//   row_ready_o   assembler accepts a row (high while filling)
//   cell_o        packed cell word
//   cell_valid_o  cell_o, mask enables and position are valid
//   cell_ready_i  downstream accepts the cell
//   t/b/l/r_msk_en_o  cell touches the top/bottom/left/right frame edge
//   cell_col_o    column index of the cell being filled or held
//   cell_row_o    row index of the cell being filled or held
//   frame_done_o  one-cycle pulse after the last cell of a frame is accepted
// -----------------------------------------------------------------------------
module cell_assembler #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int CELL_ROW_PNUM   = 8,
    parameter int CELL_COL_PNUM   = 8,
    parameter int CELL_WIDTH      = 768,
    parameter int FRAME_CELL_COLS = 40,
    parameter int FRAME_CELL_ROWS = 30,
    localparam int ROW_IN_W = (CELL_ROW_PNUM + 2) * PIXEL_WIDTH,
    localparam int COL_W    = (FRAME_CELL_COLS > 1) ? $clog2(FRAME_CELL_COLS) : 1,
    localparam int ROWS_W   = (FRAME_CELL_ROWS > 1) ? $clog2(FRAME_CELL_ROWS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ROW_IN_W-1:0]   row_i,
    input  logic                  row_valid_i,
    output logic                  row_ready_o,
    output logic [CELL_WIDTH-1:0] cell_o,
    output logic                  cell_valid_o,
    input  logic                  cell_ready_i,
    output logic                  t_msk_en_o,
    output logic                  b_msk_en_o,
    output logic                  l_msk_en_o,
    output logic                  r_msk_en_o,
    output logic [COL_W-1:0]      cell_col_o,
    output logic [ROWS_W-1:0]     cell_row_o,
    output logic                  frame_done_o
);

    localparam int ROW_BITS    = CELL_ROW_PNUM * PIXEL_WIDTH;
    localparam int INNER_BITS  = ROW_BITS * CELL_COL_PNUM;
    localparam int VSTRIP_BITS = CELL_COL_PNUM * PIXEL_WIDTH;
    localparam int LAST_BEAT   = CELL_COL_PNUM + 1;
    localparam int BEAT_W      = $clog2(CELL_COL_PNUM + 2);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic [BEAT_W-1:0]       beat_q;
    logic [BEAT_W-1:0]       slot;
    logic                    last_beat;
    logic                    row_fire;
    logic                    cell_fire;
    logic                    col_last;
    logic                    row_last;

    logic [INNER_BITS-1:0]   inner_q;
    logic [ROW_BITS-1:0]     top_q;
    logic [ROW_BITS-1:0]     bottom_q;
    logic [VSTRIP_BITS-1:0]  left_q;
    logic [VSTRIP_BITS-1:0]  right_q;

    logic [ROW_BITS-1:0]     row_inner_px;
    logic [PIXEL_WIDTH-1:0]  row_first_px;
    logic [PIXEL_WIDTH-1:0]  row_last_px;

    logic [COL_W-1:0]        pos_col_q;
    logic [ROWS_W-1:0]       pos_row_q;
    logic                    t_q;
    logic                    b_q;
    logic                    l_q;
    logic                    r_q;
    logic                    frame_done_q;

    // Split the incoming row into its corner/edge pixels and the inner run.
    // Beats 1..N-2 land in the inner block and side strips. Slot counts down
    // from the top so that inner row 0 and strip element 0 end up at the MSB
    // end of their fields.
    assign row_first_px = row_i[ROW_IN_W-1 -: PIXEL_WIDTH];
    assign row_last_px  = row_i[PIXEL_WIDTH-1:0];
    assign row_inner_px = row_i[ROW_IN_W-PIXEL_WIDTH-1 : PIXEL_WIDTH];
    assign slot         = BEAT_W'(CELL_COL_PNUM) - beat_q;
    assign last_beat    = (beat_q == BEAT_W'(LAST_BEAT));
    assign row_fire     = row_valid_i & row_ready_o;
    assign cell_fire    = cell_valid_o & cell_ready_i;
    assign col_last     = (pos_col_q == COL_W'(FRAME_CELL_COLS - 1));
    assign row_last     = (pos_row_q == ROWS_W'(FRAME_CELL_ROWS - 1));

    // State register for the fill/hold controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs. The FSM accepts rows only while
    // filling and presents the cell only while holding, so a fill never
    // overlaps a hold. This is what guarantees that the cell word stays
    // stable until it is accepted.
    always_comb begin
        state_d      = state_q;
        row_ready_o  = 1'b0;
        cell_valid_o = 1'b0;
        case (state_q)
            FILL: begin
                row_ready_o = 1'b1;
                if (row_valid_i && last_beat) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                cell_valid_o = 1'b1;
                if (cell_ready_i) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Beat counter. It advances on each accepted row and parks on the last
    // beat while the cell is held. The cell handshake clears it so that the
    // next accepted row is beat 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q <= '0;
        end else if (cell_fire) begin
            beat_q <= '0;
        end else if (row_fire && !last_beat) begin
            beat_q <= beat_q + BEAT_W'(1);
        end
    end

    // Cell storage. The first and last beats fill the top and bottom strips.
    // The beats in between fill one inner row each, plus one element of the
    // left and right strips. Corner pixels of the first and last beats are
    // never stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            inner_q  <= '0;
            top_q    <= '0;
            bottom_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
        end else if (row_fire) begin
            if (beat_q == '0) begin
                top_q <= row_inner_px;
            end else if (last_beat) begin
                bottom_q <= row_inner_px;
            end else begin
                inner_q[slot*ROW_BITS +: ROW_BITS]       <= row_inner_px;
                left_q[slot*PIXEL_WIDTH +: PIXEL_WIDTH]  <= row_first_px;
                right_q[slot*PIXEL_WIDTH +: PIXEL_WIDTH] <= row_last_px;
            end
        end
    end

    // Mask enables are captured from the current position on the final row
    // handshake. They are therefore valid in the same cycle as cell_valid_o
    // and cannot change while the cell is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_q <= 1'b0;
            b_q <= 1'b0;
            l_q <= 1'b0;
            r_q <= 1'b0;
        end else if (row_fire && last_beat) begin
            t_q <= (pos_row_q == '0);
            b_q <= row_last;
            l_q <= (pos_col_q == '0);
            r_q <= col_last;
        end
    end

    // Frame position. It steps raster-order on every accepted cell and wraps
    // at the frame edges. The frame-done pulse is registered, so it appears
    // in the cycle after the final cell of the frame is accepted and lasts
    // exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_col_q    <= '0;
            pos_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= cell_fire && col_last && row_last;
            if (cell_fire) begin
                if (col_last) begin
                    pos_col_q <= '0;
                    if (row_last) begin
                        pos_row_q <= '0;
                    end else begin
                        pos_row_q <= pos_row_q + ROWS_W'(1);
                    end
                end else begin
                    pos_col_q <= pos_col_q + COL_W'(1);
                end
            end
        end
    end

    assign cell_o       = {inner_q, top_q, left_q, right_q, bottom_q};
    assign t_msk_en_o   = t_q;
    assign b_msk_en_o   = b_q;
    assign l_msk_en_o   = l_q;
    assign r_msk_en_o   = r_q;
    assign cell_col_o   = pos_col_q;
    assign cell_row_o   = pos_row_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_cell_assembler.sv
// -----------------------------------------------------------------------------
// tb_cell_assembler
//
// Purpose:
//   Self-checking bench for cell_assembler. Three instances share one row
//   stream and one cell handshake, so they run in lockstep:
//     dut_def - default 40x30 frame
//     dut_f2  - 2x2 frame; exercises the mask corners and frame_done
//     dut_f1  - 1x1 frame; every cell is a whole frame
//   Expected cells come from a reference packer built on shift registers,
//   and from hand-computed constants for the first cell.
// -----------------------------------------------------------------------------
module tb_cell_assembler;

    localparam int CW = 768;

    typedef struct {
        string       name;
        int          lsb;
        logic [63:0] exp;
    } slice_vec_t;

    typedef struct {
        logic [7:0] base;
        bit         gaps;
        logic [3:0] exp_tblr_f2;
        int         exp_col_f2;
        int         exp_row_f2;
        bit         exp_done_f2;
    } cell_vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [79:0]   row_i;
    logic          row_valid_i;
    logic          cell_ready_i;

    logic          rr_def, rr_f2, rr_f1;
    logic [CW-1:0] cell_def, cell_f2, cell_f1;
    logic          cv_def, cv_f2, cv_f1;
    logic          t_def, b_def, l_def, r_def;
    logic          t_f2, b_f2, l_f2, r_f2;
    logic          t_f1, b_f1, l_f1, r_f1;
    logic [5:0]    col_def;
    logic [4:0]    row_def;
    logic [0:0]    col_f2, row_f2, col_f1, row_f1;
    logic          done_def, done_f2, done_f1;

    int tests_run    = 0;
    int tests_failed = 0;

    slice_vec_t slices[6];
    cell_vec_t  cells[4];

    always #5 clk = ~clk;

    cell_assembler dut_def (
        .clk(clk), .rst(rst), .row_i(row_i), .row_valid_i(row_valid_i),
        .row_ready_o(rr_def), .cell_o(cell_def), .cell_valid_o(cv_def),
        .cell_ready_i(cell_ready_i), .t_msk_en_o(t_def), .b_msk_en_o(b_def),
        .l_msk_en_o(l_def), .r_msk_en_o(r_def), .cell_col_o(col_def),
        .cell_row_o(row_def), .frame_done_o(done_def)
    );

    cell_assembler #(.FRAME_CELL_COLS(2), .FRAME_CELL_ROWS(2)) dut_f2 (
        .clk(clk), .rst(rst), .row_i(row_i), .row_valid_i(row_valid_i),
        .row_ready_o(rr_f2), .cell_o(cell_f2), .cell_valid_o(cv_f2),
        .cell_ready_i(cell_ready_i), .t_msk_en_o(t_f2), .b_msk_en_o(b_f2),
        .l_msk_en_o(l_f2), .r_msk_en_o(r_f2), .cell_col_o(col_f2),
        .cell_row_o(row_f2), .frame_done_o(done_f2)
    );

    cell_assembler #(.FRAME_CELL_COLS(1), .FRAME_CELL_ROWS(1)) dut_f1 (
        .clk(clk), .rst(rst), .row_i(row_i), .row_valid_i(row_valid_i),
        .row_ready_o(rr_f1), .cell_o(cell_f1), .cell_valid_o(cv_f1),
        .cell_ready_i(cell_ready_i), .t_msk_en_o(t_f1), .b_msk_en_o(b_f1),
        .l_msk_en_o(l_f1), .r_msk_en_o(r_f1), .cell_col_o(col_f1),
        .cell_row_o(row_f1), .frame_done_o(done_f1)
    );

    // Compare one value and report any difference.
    task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                               input logic [CW-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Build beat b of a neighbourhood: pixel p = {b,p} xor base.
    function automatic logic [79:0] make_row(input int b, input logic [7:0] base);
        logic [79:0] r;
        r = '0;
        for (int p = 0; p < 10; p++) begin
            r = {r[71:0], ({4'(b), 4'(p)} ^ base)};
        end
        return r;
    endfunction

    // Reference packer: concatenate the fields in arrival order.
    function automatic logic [CW-1:0] model_cell(input logic [79:0] rows [10]);
        logic [511:0] inner;
        logic [63:0]  left, right;
        inner = '0;
        left  = '0;
        right = '0;
        for (int k = 1; k <= 8; k++) begin
            inner = {inner[447:0], rows[k][71:8]};
            left  = {left[55:0], rows[k][79:72]};
            right = {right[55:0], rows[k][7:0]};
        end
        return {inner, rows[0][71:8], left, right, rows[9][71:8]};
    endfunction

    // Present one row and wait, within a bound, for it to be accepted. If
    // gaps are enabled, idle cycles may be inserted first, each with a 50%
    // chance.
    task automatic applyStimulus(input logic [79:0] row, input bit use_gaps);
        int  idle;
        bit  ok;
        idle = 0;
        while (use_gaps && ($urandom_range(0, 1) == 1) && (idle < 4)) begin
            row_valid_i = 1'b0;
            @(posedge clk);
            #1;
            idle++;
        end
        row_valid_i = 1'b1;
        row_i       = row;
        ok          = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            ok = rr_def;
            @(posedge clk);
            #1;
        end
        row_valid_i = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL row_handshake_timeout: got no row_ready, expected row_ready within 50 cycles");
        end
    endtask

    // Feed a full neighbourhood and check cell_valid latency around the
    // last beat. The expected cell word is returned.
    task automatic fill_cell(input logic [7:0] base, input bit use_gaps,
                             output logic [CW-1:0] exp);
        logic [79:0] rows [10];
        for (int b = 0; b < 10; b++) begin
            rows[b] = make_row(b, base);
            applyStimulus(rows[b], use_gaps);
            if (b == 8) checkOutput("valid_before_last_beat", CW'(cv_def), CW'(0));
        end
        checkOutput("valid_one_cycle_after_last_beat",
                    CW'({cv_def, cv_f2, cv_f1}), CW'(3'b111));
        exp = model_cell(rows);
    endtask

    task automatic accept_cell();
        cell_ready_i = 1'b1;
        @(posedge clk);
        #1;
        cell_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CW-1:0] exp;

        slices[0] = '{"inner_row0", 704, 64'h1112131415161718};
        slices[1] = '{"inner_row7", 256, 64'h8182838485868788};
        slices[2] = '{"top_strip",  192, 64'h0102030405060708};
        slices[3] = '{"left_strip", 128, 64'h1020304050607080};
        slices[4] = '{"right_strip", 64, 64'h1929394959697989};
        slices[5] = '{"bottom_strip", 0, 64'h9192939495969798};

        cells[0] = '{8'h21, 1'b1, 4'b1001, 1, 0, 1'b0};
        cells[1] = '{8'h42, 1'b1, 4'b0110, 0, 1, 1'b0};
        cells[2] = '{8'h63, 1'b1, 4'b0101, 1, 1, 1'b1};
        cells[3] = '{8'h84, 1'b0, 4'b1010, 0, 0, 1'b0};

        rst          = 1'b1;
        row_valid_i  = 1'b0;
        cell_ready_i = 1'b0;
        row_i        = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        checkOutput("reset_row_ready", CW'(rr_def), CW'(1));
        checkOutput("reset_cell_valid", CW'(cv_def), CW'(0));
        checkOutput("reset_cell", cell_def, '0);
        checkOutput("reset_masks", CW'({t_def, b_def, l_def, r_def}), CW'(0));
        checkOutput("reset_position", CW'({col_def, row_def}), CW'(0));
        checkOutput("reset_frame_done", CW'(done_def), CW'(0));

        // First cell with the hand-computed pattern
        fill_cell(8'h00, 1'b0, exp);
        for (int i = 0; i < 6; i++) begin
            checkOutput(slices[i].name, CW'(cell_def[slices[i].lsb +: 64]), CW'(slices[i].exp));
        end
        checkOutput("cell0_model", cell_def, exp);
        checkOutput("cell0_masks_def", CW'({t_def, b_def, l_def, r_def}), CW'(4'b1010));
        checkOutput("cell0_masks_f2", CW'({t_f2, b_f2, l_f2, r_f2}), CW'(4'b1010));
        checkOutput("cell0_masks_f1", CW'({t_f1, b_f1, l_f1, r_f1}), CW'(4'b1111));
        accept_cell();
        checkOutput("cell0_ready_after_accept", CW'({rr_def, rr_f2, rr_f1}), CW'(3'b111));
        checkOutput("cell0_done", CW'({done_def, done_f2, done_f1}), CW'(3'b001));
        @(posedge clk);
        #1;
        checkOutput("cell0_done_one_cycle", CW'({done_def, done_f2, done_f1}), CW'(3'b000));

        // Rest of the 2x2 frame, then wrap to the next frame
        for (int i = 0; i < 4; i++) begin
            fill_cell(cells[i].base, cells[i].gaps, exp);
            checkOutput($sformatf("cell%0d_def", i + 1), cell_def, exp);
            checkOutput($sformatf("cell%0d_f2", i + 1), cell_f2, exp);
            checkOutput($sformatf("cell%0d_f1", i + 1), cell_f1, exp);
            checkOutput($sformatf("cell%0d_masks_f2", i + 1),
                        CW'({t_f2, b_f2, l_f2, r_f2}), CW'(cells[i].exp_tblr_f2));
            checkOutput($sformatf("cell%0d_pos_f2", i + 1), CW'({col_f2, row_f2}),
                        CW'({1'(cells[i].exp_col_f2), 1'(cells[i].exp_row_f2)}));
            checkOutput($sformatf("cell%0d_masks_f1", i + 1),
                        CW'({t_f1, b_f1, l_f1, r_f1}), CW'(4'b1111));
            checkOutput($sformatf("cell%0d_pos_f1", i + 1), CW'({col_f1, row_f1}), CW'(0));
            checkOutput($sformatf("cell%0d_masks_def", i + 1),
                        CW'({t_def, b_def, l_def, r_def}), CW'(4'b1000));
            checkOutput($sformatf("cell%0d_col_def", i + 1), CW'(col_def), CW'(i + 1));
            accept_cell();
            checkOutput($sformatf("cell%0d_done", i + 1), CW'({done_def, done_f2, done_f1}),
                        CW'({1'b0, cells[i].exp_done_f2, 1'b1}));
            @(posedge clk);
            #1;
            checkOutput($sformatf("cell%0d_done_one_cycle", i + 1),
                        CW'({done_def, done_f2, done_f1}), CW'(3'b000));
        end

        // Backpressure: hold the cell for 20 cycles while rows keep coming
        fill_cell(8'hC3, 1'b0, exp);
        row_valid_i = 1'b1;
        row_i       = make_row(0, 8'hEE);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_row_ready", CW'({rr_def, rr_f2, rr_f1}), CW'(3'b000));
            checkOutput("bp_cell_valid", CW'(cv_def), CW'(1));
            checkOutput("bp_cell_stable", cell_def, exp);
            checkOutput("bp_masks_stable", CW'({t_def, b_def, l_def, r_def}), CW'(4'b1000));
        end
        row_valid_i = 1'b0;
        accept_cell();
        checkOutput("bp_ready_after_accept", CW'({rr_def, rr_f2, rr_f1}), CW'(3'b111));
        checkOutput("bp_valid_after_accept", CW'(cv_def), CW'(0));
        checkOutput("bp_col_after_accept", CW'(col_def), CW'(6));

        // Reset partway through a fill
        for (int b = 0; b < 5; b++) begin
            applyStimulus(make_row(b, 8'hFF), 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_valid", CW'(cv_def), CW'(0));
        checkOutput("midrst_position", CW'({col_def, row_def}), CW'(0));
        checkOutput("midrst_row_ready", CW'(rr_def), CW'(1));
        checkOutput("midrst_cell_cleared", cell_def, '0);
        fill_cell(8'h5A, 1'b0, exp);
        checkOutput("midrst_clean_cell", cell_def, exp);
        checkOutput("midrst_masks", CW'({t_def, b_def, l_def, r_def}), CW'(4'b1010));
        checkOutput("midrst_col", CW'(col_def), CW'(0));
        accept_cell();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
